// File: rtl/mastermind_game_ctrl_pkg.sv
// Shared definitions for the Mastermind game sequencer: sizes, FSM state
// encoding and the {peg3..peg0} packing of code/guess words.
package mastermind_game_ctrl_pkg;

  localparam int NUM_TURNS  = 8;
  localparam int NUM_PEGS   = 4;
  localparam int COLOR_W    = 3;
  localparam int NUM_COLORS = 2 ** COLOR_W;
  localparam int TURN_W     = $clog2(NUM_TURNS);
  localparam int CODE_W     = NUM_PEGS * COLOR_W;
  localparam int CNT_W      = 3;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_GUESS  = 3'd1,
    S_COMMIT = 3'd2,
    S_SCORE  = 3'd3,
    S_DECIDE = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  // Peg idx lives in bits [idx*COLOR_W +: COLOR_W]; peg0 is the LSB field.
  function automatic logic [COLOR_W-1:0] peg_of(input logic [CODE_W-1:0] word,
                                                input int idx);
    return word[idx*COLOR_W +: COLOR_W];
  endfunction

endpackage

// File: rtl/mastermind_game_ctrl_peg_color_count.sv
// Counts how many pegs of a packed 4-peg word carry a given colour (0..4).
module peg_color_count
  import mastermind_game_ctrl_pkg::*;
(
  input  logic [11:0] word,
  input  logic [2:0]  color,
  output logic [2:0]  count
);

  // Combinational occurrence count over all pegs.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (peg_of(word, i) == color) count = count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: latches the secret, accepts guesses on select
// edges, writes history, scores black/white pegs one colour per cycle and
// tracks turn / win / game-over.
module mastermind_game_ctrl
  import mastermind_game_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic        mode,
  input  logic [11:0] code_in,
  input  logic [11:0] guess_in,
  output logic        guess_enable,
  output logic        hist_we,
  output logic [2:0]  hist_addr,
  output logic [11:0] hist_data,
  output logic [2:0]  black,
  output logic [2:0]  white,
  output logic        score_valid,
  output logic [2:0]  turn,
  output logic        win,
  output logic        game_over
);

  localparam logic [TURN_W-1:0]  LAST_TURN  = TURN_W'(NUM_TURNS - 1);
  localparam logic [COLOR_W-1:0] LAST_COLOR = COLOR_W'(NUM_COLORS - 1);
  localparam logic [CNT_W-1:0]   ALL_PEGS   = CNT_W'(NUM_PEGS);

  state_t      state;
  state_t      state_nxt;
  logic        select_q;
  logic        sel_edge;
  logic        accept;
  logic [11:0] code_q;
  logic [11:0] guess_q;
  logic [2:0]  color_idx;
  logic [2:0]  acc;
  logic [2:0]  acc_nxt;
  logic [2:0]  exact;
  logic [2:0]  exact_nxt;
  logic [2:0]  cnt_code;
  logic [2:0]  cnt_guess;
  logic [2:0]  min_cnt;
  logic        score_last;

  // A held button gives one edge; mode=1 (history browse) masks it.
  assign sel_edge   = select & ~select_q;
  assign accept     = sel_edge & ~mode;
  assign score_last = (state == S_SCORE) && (color_idx == LAST_COLOR);

  peg_color_count u_code_cnt (
    .word  (code_q),
    .color (color_idx),
    .count (cnt_code)
  );

  peg_color_count u_guess_cnt (
    .word  (guess_q),
    .color (color_idx),
    .count (cnt_guess)
  );

  // Exact-position matches and the running colour-match accumulator input.
  always_comb begin
    exact_nxt = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (peg_of(code_q, i) == peg_of(guess_q, i)) exact_nxt = exact_nxt + CNT_W'(1);
    end
    min_cnt = (cnt_code < cnt_guess) ? cnt_code : cnt_guess;
    acc_nxt = acc + min_cnt;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  // FSM next-state logic; select outside S_GUESS/S_OVER is dropped, not queued.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   state_nxt = S_GUESS;
      S_GUESS:  if (accept) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_SCORE;
      S_SCORE:  if (color_idx == LAST_COLOR) state_nxt = S_DECIDE;
      S_DECIDE: begin
        if (black == ALL_PEGS || turn == LAST_TURN) state_nxt = S_OVER;
        else                                        state_nxt = S_GUESS;
      end
      S_OVER:   if (accept) state_nxt = S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  // FSM outputs; history bus is quiet outside the commit cycle.
  always_comb begin
    guess_enable = (state == S_GUESS);
    hist_we      = (state == S_COMMIT);
    hist_addr    = hist_we ? turn : 3'd0;
    hist_data    = hist_we ? guess_q : 12'd0;
  end

  // Select edge detector history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) select_q <= 1'b0;
    else       select_q <= select;
  end

  // Secret code and guess latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q  <= '0;
      guess_q <= '0;
    end else begin
      if (state == S_LOAD)            code_q  <= code_in;
      if (state == S_GUESS && accept) guess_q <= guess_in;
    end
  end

  // Scoring: exact count captured at commit, then one colour per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exact     <= '0;
      acc       <= '0;
      color_idx <= '0;
    end else if (state == S_COMMIT) begin
      exact     <= exact_nxt;
      acc       <= '0;
      color_idx <= '0;
    end else if (state == S_SCORE) begin
      acc       <= acc_nxt;
      color_idx <= color_idx + COLOR_W'(1);
    end
  end

  // Published score: loaded with the last colour so it is valid in S_DECIDE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      black       <= '0;
      white       <= '0;
      score_valid <= 1'b0;
    end else begin
      score_valid <= score_last;
      if (score_last) begin
        black <= exact;
        white <= acc_nxt - exact;
      end else if (state == S_OVER && accept) begin
        black <= '0;
        white <= '0;
      end
    end
  end

  // Turn counter and sticky game result; win outranks the last-turn loss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turn      <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else if (state == S_DECIDE) begin
      if (black == ALL_PEGS) begin
        win       <= 1'b1;
        game_over <= 1'b1;
      end else if (turn == LAST_TURN) begin
        game_over <= 1'b1;
      end else begin
        turn <= turn + TURN_W'(1);
      end
    end else if (state == S_OVER && accept) begin
      turn      <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Bench for mastermind_game_ctrl: directed games plus randomized play,
// checked every cycle against a cycle-count reference of the game rules.
module tb_mastermind_game_ctrl;

  logic        clk;
  logic        reset;
  logic        select;
  logic        mode;
  logic [11:0] code_in;
  logic [11:0] guess_in;
  logic        guess_enable;
  logic        hist_we;
  logic [2:0]  hist_addr;
  logic [11:0] hist_data;
  logic [2:0]  black;
  logic [2:0]  white;
  logic        score_valid;
  logic [2:0]  turn;
  logic        win;
  logic        game_over;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  mastermind_game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .select       (select),
    .mode         (mode),
    .code_in      (code_in),
    .guess_in     (guess_in),
    .guess_enable (guess_enable),
    .hist_we      (hist_we),
    .hist_addr    (hist_addr),
    .hist_data    (hist_data),
    .black        (black),
    .white        (white),
    .score_valid  (score_valid),
    .turn         (turn),
    .win          (win),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Game rules: black = same colour same position; white = sum over colours of
  // min(count in code, count in guess) minus black.
  function automatic void score(input logic [11:0] c, input logic [11:0] g,
                                output int b, output int w);
    int cc[8];
    int gc[8];
    int tot;
    int cp;
    int gp;
    for (int k = 0; k < 8; k++) begin cc[k] = 0; gc[k] = 0; end
    b = 0;
    tot = 0;
    for (int p = 0; p < 4; p++) begin
      cp = int'(c[p*3 +: 3]);
      gp = int'(g[p*3 +: 3]);
      if (cp == gp) b++;
      cc[cp]++;
      gc[gp]++;
    end
    for (int k = 0; k < 8; k++) tot += (cc[k] < gc[k]) ? cc[k] : gc[k];
    w = tot - b;
  endfunction

  // Model state: what phase of a game we are in, counted in cycles since the
  // guess was accepted (1 = history write, 10 = score published).
  bit          m_loading, m_accepting, m_done, m_win, m_sel_prev;
  int          m_since, m_turn, m_black, m_white;
  logic [11:0] m_secret, m_guess;

  task automatic m_reset();
    m_loading   = 1; m_accepting = 0; m_done = 0; m_win = 0; m_sel_prev = 0;
    m_since     = 0; m_turn = 0; m_black = 0; m_white = 0;
    m_secret    = '0; m_guess = '0;
  endtask

  task automatic m_step();
    bit take;
    int b;
    int w;
    take = select && !m_sel_prev && !mode;
    m_sel_prev = select;
    if (m_loading) begin
      m_secret = code_in; m_loading = 0; m_accepting = 1;
    end else if (m_accepting) begin
      if (take) begin m_guess = guess_in; m_accepting = 0; m_since = 1; end
    end else if (m_since == 10) begin
      m_since = 0;
      if (m_black == 4)     begin m_win = 1; m_done = 1; end
      else if (m_turn == 7) m_done = 1;
      else                  begin m_turn++; m_accepting = 1; end
    end else if (m_since > 0) begin
      m_since++;
      if (m_since == 10) begin score(m_secret, m_guess, b, w); m_black = b; m_white = w; end
    end else if (m_done) begin
      if (take) begin
        m_turn = 0; m_win = 0; m_done = 0; m_black = 0; m_white = 0; m_loading = 1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset();
      else       m_step();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cyc_guess_enable", guess_enable, m_accepting);
        chk("cyc_hist_we",      hist_we,      m_since == 1);
        chk("cyc_hist_addr",    hist_addr,    (m_since == 1) ? m_turn : 0);
        chk("cyc_hist_data",    hist_data,    (m_since == 1) ? int'(m_guess) : 0);
        chk("cyc_score_valid",  score_valid,  m_since == 10);
        chk("cyc_black",        black,        m_black);
        chk("cyc_white",        white,        m_white);
        chk("cyc_turn",         turn,         m_turn);
        chk("cyc_win",          win,          m_win);
        chk("cyc_game_over",    game_over,    m_done);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_guess_enable"}, guess_enable, 0);
    chk({tag, "_hist_we"},      hist_we,      0);
    chk({tag, "_hist_addr"},    hist_addr,    0);
    chk({tag, "_hist_data"},    hist_data,    0);
    chk({tag, "_black"},        black,        0);
    chk({tag, "_white"},        white,        0);
    chk({tag, "_score_valid"},  score_valid,  0);
    chk({tag, "_turn"},         turn,         0);
    chk({tag, "_win"},          win,          0);
    chk({tag, "_game_over"},    game_over,    0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_zero(tag);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ge();
    int n = 0;
    while (!guess_enable && n < 40) begin tick(); n++; end
    chk("wait_guess_enable", guess_enable, 1);
  endtask

  task automatic wait_sv();
    int n = 0;
    while (!score_valid && n < 40) begin tick(); n++; end
    chk("wait_score_valid", score_valid, 1);
  endtask

  localparam logic [11:0] C1234 = {3'd1, 3'd2, 3'd3, 3'd4};
  localparam logic [11:0] C4321 = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [11:0] C5511 = {3'd5, 3'd5, 3'd1, 3'd1};
  localparam logic [11:0] C5157 = {3'd5, 3'd1, 3'd5, 3'd7};
  localparam logic [11:0] C7654 = {3'd7, 3'd6, 3'd5, 3'd4};

  initial begin
    int n, hw, svn, sb, sw, b, w;
    reset = 1'b1; select = 1'b0; mode = 1'b0; code_in = '0; guess_in = '0;
    tick();
    tick();
    cmp_en = 1;

    // Hand-computed scores pinning the reference model.
    score(C1234, C1234, b, w); chk("pin_1234_b", b, 4); chk("pin_1234_w", w, 0);
    score(C1234, C4321, b, w); chk("pin_4321_b", b, 0); chk("pin_4321_w", w, 4);
    score(C5511, C5157, b, w); chk("pin_5157_b", b, 1); chk("pin_5157_w", w, 2);
    score(12'd0, 12'd1, b, w); chk("pin_0001_b", b, 3); chk("pin_0001_w", w, 0);

    // Test 1: winning guess, latency of history write and score.
    code_in = C1234;
    do_reset("t1_reset");
    wait_ge();
    guess_in = C1234;
    select = 1'b1;
    n = 0;
    while (!hist_we && n < 20) begin tick(); n++; end
    chk("t1_hist_we_latency", n, 1);
    chk("t1_hist_data", hist_data, C1234);
    while (!score_valid && n < 30) begin tick(); n++; end
    chk("t1_score_latency", n, 10);
    chk("t1_black", black, 4);
    chk("t1_white", white, 0);
    tick();
    chk("t1_win", win, 1);
    chk("t1_game_over", game_over, 1);
    chk("t1_guess_enable_off", guess_enable, 0);
    select = 1'b0;
    tick();

    // Test 2: restart from game over, all colours displaced.
    select = 1'b1; tick(); select = 1'b0;
    wait_ge();
    chk("t2_turn_start", turn, 0);
    guess_in = C4321;
    select = 1'b1; tick(); select = 1'b0;
    wait_sv();
    chk("t2_black", black, 0);
    chk("t2_white", white, 4);
    tick();
    chk("t2_turn_next", turn, 1);
    chk("t2_guess_enable", guess_enable, 1);

    // Test 3: repeated colours, long-held select.
    code_in = C5511;
    do_reset("t3_reset");
    wait_ge();
    guess_in = C5157;
    select = 1'b1;
    hw = 0; svn = 0; sb = 0; sw = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      hw += int'(hist_we);
      if (score_valid) begin svn++; sb = black; sw = white; end
    end
    select = 1'b0;
    chk("t3_hist_we_count", hw, 1);
    chk("t3_sv_count", svn, 1);
    chk("t3_black", sb, 1);
    chk("t3_white", sw, 2);

    // Test 4: eight wrong guesses exhaust the game.
    code_in = C7654;
    do_reset("t4_reset");
    for (int i = 0; i < 8; i++) begin
      wait_ge();
      guess_in = {9'($urandom), 3'd0};
      select = 1'b1;
      n = 0;
      while (!hist_we && n < 5) begin tick(); n++; end
      chk("t4_hist_addr", hist_addr, i);
      select = 1'b0;
      wait_sv();
    end
    tick();
    chk("t4_game_over", game_over, 1);
    chk("t4_win", win, 0);
    chk("t4_turn_last", turn, 7);
    chk("t4_guess_enable", guess_enable, 0);
    select = 1'b1; tick(); select = 1'b0;
    chk("t4_turn_cleared", turn, 0);
    chk("t4_game_over_cleared", game_over, 0);
    chk("t4_load_no_ge", guess_enable, 0);
    tick();
    chk("t4_ge_after_load", guess_enable, 1);

    // Test 5: history mode masks select; select while scoring is ignored.
    mode = 1'b1; select = 1'b1; hw = 0;
    for (int k = 0; k < 5; k++) begin tick(); hw += int'(hist_we); end
    chk("t5_mode_hist_we", hw, 0);
    chk("t5_mode_ge", guess_enable, 1);
    chk("t5_mode_turn", turn, 0);
    select = 1'b0; mode = 1'b0; tick();
    guess_in = 12'd0;
    select = 1'b1; tick(); select = 1'b0;
    chk("t5_hist_we", hist_we, 1);
    repeat (3) tick();
    select = 1'b1;
    hw = 0; svn = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 1) select = 1'b0;
      hw  += int'(hist_we);
      svn += int'(score_valid);
    end
    chk("t5_score_select_hist_we", hw, 0);
    chk("t5_score_select_sv", svn, 1);

    // Test 6: reset on the 4th scoring cycle.
    wait_ge();
    guess_in = 12'd0;
    select = 1'b1; tick(); select = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check_zero("t6_mid_score");
    tick();
    reset = 1'b0;
    tick();
    chk("t6_restart_ge", guess_enable, 1);
    svn = 0; hw = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      svn += int'(score_valid);
      hw  += int'(hist_we);
    end
    chk("t6_no_sv", svn, 0);
    chk("t6_no_hist_we", hw, 0);

    // Randomized play, checked by the per-cycle comparison.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) select = ~select;
      mode = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) code_in = 12'($urandom);
      guess_in = ($urandom_range(0, 4) == 0) ? code_in : 12'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
